pipe_stage_skid_reg: RTL and testbench

Parametrised pipeline stage register with a valid/ready handshake, a one-entry skid buffer, a bubble-safe flush and a saturating stall counter. It replaces the fixed-field stage registers between decode/execute, execute/memory and memory/writeback. Control bits (WB/MEM enables, branch, S, EXE command) and datapath fields (PC, operands, immediates, destination, status flags) are packed by the instantiating stage into two buses. This lets a downstream stall back-pressure the upstream stage without losing an instruction.

---
 rtl/pipe_stage_skid_reg_if.sv | 25 ++
 rtl/pipe_stage_skid_reg.sv | 131 +++++++++++++
 tb/tb_pipe_stage_skid_reg.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_skid_reg_if.sv
// Valid/ready handshake bundle for a pipeline stage register.
// The stage uses the slave view; the upstream/downstream environment uses master.
interface pipe_stage_skid_reg_if #(
  parameter int CTRL_W = 12,
  parameter int DATA_W = 112
);
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_ctrl, in_data, out_ready,
    input  in_ready, out_valid, out_ctrl, out_data
  );

  modport slave (
    input  in_valid, in_ctrl, in_data, out_ready,
    output in_ready, out_valid, out_ctrl, out_data
  );
endinterface

// File: rtl/pipe_stage_skid_reg.sv
// Pipeline stage register with a one-entry skid buffer, flush and a saturating
// stall counter. Main entry drives the outputs; skid entry absorbs one overflow beat.
module pipe_stage_skid_reg #(
  parameter int CTRL_W     = 12,
  parameter int DATA_W     = 112,
  parameter bit CLEAR_DATA = 1'b0,
  parameter int CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 stall_clr,
  output logic [CNT_W-1:0]     stall_cnt,
  pipe_stage_skid_reg_if.slave bus
);
  // State bits are {mv, sv}; (0,1) cannot be reached.
  localparam logic [1:0] EMPTY = 2'b00;
  localparam logic [1:0] FULL1 = 2'b10;
  localparam logic [1:0] FULL2 = 2'b11;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]        state_r, state_s;
  logic [CTRL_W-1:0] m_ctrl_r, m_ctrl_s, s_ctrl_r, s_ctrl_s;
  logic [DATA_W-1:0] m_data_r, m_data_s, s_data_r, s_data_s;
  logic              in_ready_r;
  logic [CNT_W-1:0]  stall_cnt_r;
  logic              in_fire_s, out_fire_s;

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = state_r[1];
  assign bus.out_ctrl  = m_ctrl_r;
  assign bus.out_data  = m_data_r;
  assign stall_cnt     = stall_cnt_r;

  // Next-state and entry-contents selection for the two-entry buffer.
  always_comb begin
    state_s    = state_r;
    m_ctrl_s   = m_ctrl_r;
    m_data_s   = m_data_r;
    s_ctrl_s   = s_ctrl_r;
    s_data_s   = s_data_r;
    in_fire_s  = bus.in_valid & in_ready_r;
    out_fire_s = state_r[1] & bus.out_ready;
    if (flush) begin
      state_s  = EMPTY;
      m_ctrl_s = '0;
      s_ctrl_s = '0;
      if (CLEAR_DATA) begin
        m_data_s = '0;
        s_data_s = '0;
      end else begin
        m_data_s = m_data_r;
        s_data_s = s_data_r;
      end
    end else begin
      case (state_r)
        EMPTY: begin
          if (in_fire_s) begin
            state_s  = FULL1;
            m_ctrl_s = bus.in_ctrl;
            m_data_s = bus.in_data;
          end else begin
            m_ctrl_s = '0;
          end
        end
        FULL1: begin
          if (out_fire_s && in_fire_s) begin
            m_ctrl_s = bus.in_ctrl;
            m_data_s = bus.in_data;
          end else if (out_fire_s) begin
            state_s  = EMPTY;
            m_ctrl_s = '0;
          end else if (in_fire_s) begin
            state_s  = FULL2;
            s_ctrl_s = bus.in_ctrl;
            s_data_s = bus.in_data;
          end else begin
            state_s  = FULL1;
          end
        end
        FULL2: begin
          // in_ready is low here, so only the skid-to-main move can happen.
          if (out_fire_s) begin
            state_s  = FULL1;
            m_ctrl_s = s_ctrl_r;
            m_data_s = s_data_r;
          end else begin
            state_s  = FULL2;
          end
        end
        default: begin
          state_s  = EMPTY;
          m_ctrl_s = '0;
          s_ctrl_s = '0;
        end
      endcase
    end
  end

  // Buffer state, contents and registered in_ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= EMPTY;
      m_ctrl_r   <= '0;
      m_data_r   <= '0;
      s_ctrl_r   <= '0;
      s_data_r   <= '0;
      in_ready_r <= 1'b1;
    end else begin
      state_r    <= state_s;
      m_ctrl_r   <= m_ctrl_s;
      m_data_r   <= m_data_s;
      s_ctrl_r   <= s_ctrl_s;
      s_data_r   <= s_data_s;
      in_ready_r <= ~state_s[0];
    end
  end

  // Saturating count of cycles the presented beat is held back; flush leaves it alone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_r <= '0;
    end else if (stall_clr) begin
      stall_cnt_r <= '0;
    end else if (state_r[1] && !bus.out_ready && (stall_cnt_r != CNT_MAX)) begin
      stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end
endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Bench for pipe_stage_skid_reg: two instances (keep-data/16-bit counter and
// clear-data/2-bit counter) share one stimulus and are checked against a queue model.
module tb_pipe_stage_skid_reg;
  typedef struct packed {
    logic [11:0]  c;
    logic [111:0] d;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         flush = 1'b0;
  logic         stall_clr = 1'b0;
  logic         in_valid = 1'b0;
  logic [11:0]  in_ctrl = '0;
  logic [111:0] in_data = '0;
  logic         out_ready = 1'b0;
  logic [15:0]  stall_cnt0;
  logic [1:0]   stall_cnt1;

  int vectors = 0;
  int miscompares = 0;
  bit started = 1'b0;

  pipe_stage_skid_reg_if #(.CTRL_W(12), .DATA_W(112)) bus0 ();
  pipe_stage_skid_reg_if #(.CTRL_W(12), .DATA_W(112)) bus1 ();

  assign bus0.in_valid  = in_valid;
  assign bus0.in_ctrl   = in_ctrl;
  assign bus0.in_data   = in_data;
  assign bus0.out_ready = out_ready;
  assign bus1.in_valid  = in_valid;
  assign bus1.in_ctrl   = in_ctrl;
  assign bus1.in_data   = in_data;
  assign bus1.out_ready = out_ready;

  pipe_stage_skid_reg #(.CTRL_W(12), .DATA_W(112), .CLEAR_DATA(1'b0), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .flush(flush), .stall_clr(stall_clr),
    .stall_cnt(stall_cnt0), .bus(bus0)
  );
  pipe_stage_skid_reg #(.CTRL_W(12), .DATA_W(112), .CLEAR_DATA(1'b1), .CNT_W(2)) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .stall_clr(stall_clr),
    .stall_cnt(stall_cnt1), .bus(bus1)
  );

  always #5 clk = ~clk;

  // Model: an order-preserving queue of at most two beats plus last-presented data.
  beat_t        q[$];
  logic [111:0] stale0 = '0;
  logic [111:0] stale1 = '0;
  int           cnt0 = 0;
  int           cnt1 = 0;
  bit           m_fi, m_fo;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      stale0 = '0;
      stale1 = '0;
      cnt0 = 0;
      cnt1 = 0;
    end else begin
      m_fi = in_valid && (q.size() < 2);
      m_fo = (q.size() > 0) && out_ready;
      if (stall_clr) begin
        cnt0 = 0;
        cnt1 = 0;
      end else if ((q.size() > 0) && !out_ready) begin
        if (cnt0 < 65535) cnt0++;
        if (cnt1 < 3) cnt1++;
      end
      if (flush) begin
        q.delete();
        stale1 = '0;
      end else begin
        if (m_fo) void'(q.pop_front());
        if (m_fi) q.push_back('{c: in_ctrl, d: in_data});
      end
      if (q.size() > 0) begin
        stale0 = q[0].d;
        stale1 = q[0].d;
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (started) begin
      automatic logic        ev = (q.size() > 0);
      automatic logic [11:0] ec = ev ? q[0].c : 12'h000;
      chk("out_valid0", 128'(bus0.out_valid), 128'(ev));
      chk("out_valid1", 128'(bus1.out_valid), 128'(ev));
      chk("in_ready0",  128'(bus0.in_ready), 128'(q.size() < 2));
      chk("in_ready1",  128'(bus1.in_ready), 128'(q.size() < 2));
      chk("out_ctrl0",  128'(bus0.out_ctrl), 128'(ec));
      chk("out_ctrl1",  128'(bus1.out_ctrl), 128'(ec));
      chk("out_data0",  128'(bus0.out_data), 128'(stale0));
      chk("out_data1",  128'(bus1.out_data), 128'(stale1));
      chk("stall_cnt0", 128'(stall_cnt0), 128'(cnt0));
      chk("stall_cnt1", 128'(stall_cnt1), 128'(cnt1));
    end
  end

  task automatic cyc(input bit v, input logic [111:0] id, input bit ordy,
                     input bit fl, input bit clr);
    in_valid  = v;
    in_data   = id;
    in_ctrl   = {4'hA, id[7:0]};
    out_ready = ordy;
    flush     = fl;
    stall_clr = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with a live upstream beat.
    rst = 1'b0;
    in_valid = 1'b1;
    in_ctrl = 12'hFFF;
    in_data = '1;
    @(posedge clk);
    #1;
    started = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_out_valid", 128'(bus0.out_valid), 128'(1'b0));
    chk("rst_out_ctrl",  128'(bus0.out_ctrl), 128'(12'h000));
    chk("rst_in_ready",  128'(bus0.in_ready), 128'(1'b1));
    chk("rst_stall_cnt", 128'(stall_cnt0), 128'(16'h0000));
    chk("rst_out_data0", 128'(bus0.out_data), 128'(112'h0));
    chk("rst_out_data1", 128'(bus1.out_data), 128'(112'h0));
    in_valid = 1'b0;
    rst = 1'b1;

    // Streaming at full rate: each beat appears one edge after its in_fire.
    for (int k = 1; k <= 8; k++) begin
      cyc(1'b1, 112'(k), 1'b1, 1'b0, 1'b0);
      chk("stream_data", 128'(bus0.out_data), 128'(k));
      chk("stream_in_ready", 128'(bus0.in_ready), 128'(1'b1));
    end
    cyc(1'b0, 112'h0, 1'b1, 1'b0, 1'b0);

    // A,B,C with a three-cycle downstream stall while A is presented.
    cyc(1'b1, 112'h11, 1'b1, 1'b0, 1'b0);
    chk("abc_A", 128'(bus0.out_data), 128'(112'h11));
    cyc(1'b1, 112'h12, 1'b0, 1'b0, 1'b0);
    chk("abc_skid_in_ready", 128'(bus0.in_ready), 128'(1'b0));
    cyc(1'b1, 112'h13, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 112'h13, 1'b0, 1'b0, 1'b0);
    chk("abc_hold_A", 128'(bus0.out_data), 128'(112'h11));
    chk("abc_stall3", 128'(stall_cnt0), 128'(16'd3));
    cyc(1'b1, 112'h13, 1'b1, 1'b0, 1'b0);
    chk("abc_B", 128'(bus0.out_data), 128'(112'h12));
    cyc(1'b1, 112'h13, 1'b1, 1'b0, 1'b0);
    chk("abc_C", 128'(bus0.out_data), 128'(112'h13));
    cyc(1'b0, 112'h0, 1'b1, 1'b0, 1'b0);
    chk("abc_empty", 128'(bus0.out_valid), 128'(1'b0));

    // Flush in FULL2 with D offered; E must then come out alone.
    cyc(1'b1, 112'h21, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 112'h22, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 112'h2D, 1'b0, 1'b1, 1'b0);
    chk("flush_valid", 128'(bus0.out_valid), 128'(1'b0));
    chk("flush_ctrl",  128'(bus0.out_ctrl), 128'(12'h000));
    chk("flush_in_ready", 128'(bus0.in_ready), 128'(1'b1));
    cyc(1'b1, 112'h2E, 1'b1, 1'b0, 1'b0);
    chk("flush_E", 128'(bus0.out_data), 128'(112'h2E));
    cyc(1'b0, 112'h0, 1'b1, 1'b0, 1'b0);
    chk("flush_E_alone", 128'(bus0.out_valid), 128'(1'b0));

    // Flush while a beat fires into an empty stage: dropped.
    cyc(1'b1, 112'h2F, 1'b1, 1'b1, 1'b0);
    chk("flush_drop", 128'(bus0.out_valid), 128'(1'b0));

    // Flush in FULL1: data retained vs cleared depending on CLEAR_DATA.
    cyc(1'b1, 112'h33, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 112'h0, 1'b0, 1'b1, 1'b0);
    chk("keep_data0", 128'(bus0.out_data), 128'(112'h33));
    chk("clear_data1", 128'(bus1.out_data), 128'(112'h0));
    chk("keep_ctrl0", 128'(bus0.out_ctrl), 128'(12'h000));

    // Counter saturation on the 2-bit instance, then clear beating increment.
    cyc(1'b0, 112'h0, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 112'h44, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) cyc(1'b0, 112'h0, 1'b0, 1'b0, 1'b0);
    chk("sat_cnt1", 128'(stall_cnt1), 128'(2'd3));
    chk("sat_cnt0", 128'(stall_cnt0), 128'(16'd6));
    cyc(1'b0, 112'h0, 1'b0, 1'b0, 1'b1);
    chk("clr_cnt1", 128'(stall_cnt1), 128'(2'd0));
    chk("clr_cnt0", 128'(stall_cnt0), 128'(16'd0));
    cyc(1'b0, 112'h0, 1'b1, 1'b0, 1'b0);

    // Mixed valid/ready pattern, checked cycle by cycle against the model.
    for (int i = 0; i < 48; i++)
      cyc((i % 3) != 1, 112'(8'h50 + i), (i % 4) != 3, i == 29, i == 40);

    // Asynchronous reset in the middle of a FULL2 hold.
    cyc(1'b1, 112'h61, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 112'h62, 1'b0, 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_valid", 128'(bus0.out_valid), 128'(1'b0));
    chk("async_rst_in_ready", 128'(bus0.in_ready), 128'(1'b1));
    chk("async_rst_data", 128'(bus0.out_data), 128'(112'h0));
    in_valid = 1'b0;
    #1 rst = 1'b1;
    cyc(1'b1, 112'h71, 1'b1, 1'b0, 1'b0);
    chk("post_rst_beat", 128'(bus0.out_data), 128'(112'h71));
    cyc(1'b0, 112'h0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 112'h0, 1'b1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
